// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: decodes RAM1/RAM2/UART regions and runs a
// wait-stated FSM driving registered SRAM/UART strobes, stalling until done.
module mem_access_ctrl #(
    parameter int unsigned          DATA_W         = 16,
    parameter int unsigned          ADDR_W         = 16,
    parameter logic [ADDR_W-1:0]    RAM1_BASE      = ADDR_W'(16'h8000),
    parameter logic [ADDR_W-1:0]    UART_DATA_ADDR = ADDR_W'(16'hBF00),
    parameter logic [ADDR_W-1:0]    UART_STAT_ADDR = ADDR_W'(16'hBF01),
    parameter int unsigned          RAM_WAIT       = 1,
    parameter int unsigned          UART_WAIT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              ram1_en_o,
    output logic              ram1_oe_o,
    output logic              ram1_we_o,
    output logic              ram2_en_o,
    output logic              ram2_oe_o,
    output logic              ram2_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram1_dout_o,
    output logic [DATA_W-1:0] ram2_dout_o,
    output logic              ram1_doe_o,
    output logic              ram2_doe_o,
    input  logic [DATA_W-1:0] ram1_din_i,
    input  logic [DATA_W-1:0] ram2_din_i,
    output logic              uart_rdn_o,
    output logic              uart_wrn_o,
    input  logic              uart_data_ready_i,
    input  logic              uart_tbre_i,
    input  logic              uart_tsre_i
);

    localparam int unsigned MAX_WAIT = (RAM_WAIT > UART_WAIT) ? RAM_WAIT : UART_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, RAM_ACC, UART_RD, UART_WR, DONE} state_t;
    typedef enum logic [1:0] {REG_RAM2, REG_RAM1, REG_UDATA, REG_STAT} region_t;

    state_t              state_q, state_d;
    region_t             region_q, region_d, region_dec;
    logic                write_q, write_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                ram1_en_q, ram1_oe_q, ram1_we_q, ram1_doe_q;
    logic                ram1_en_d, ram1_oe_d, ram1_we_d, ram1_doe_d;
    logic                ram2_en_q, ram2_oe_q, ram2_we_q, ram2_doe_q;
    logic                ram2_en_d, ram2_oe_d, ram2_we_d, ram2_doe_d;
    logic                rdn_q, wrn_q, rdn_d, wrn_d;
    logic                req_c;
    logic                ram_acc_c;

    assign req_c = memread_i | memwrite_i;

    // UART addresses take priority over the RAM1 range they sit inside
    assign region_dec = (addr_i == UART_STAT_ADDR) ? REG_STAT  :
                        (addr_i == UART_DATA_ADDR) ? REG_UDATA :
                        (addr_i >= RAM1_BASE)      ? REG_RAM1  : REG_RAM2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        region_d = region_q;
        write_d  = write_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    write_d  = memwrite_i;
                    region_d = region_dec;
                    case (region_dec)
                        REG_RAM1, REG_RAM2: begin
                            state_d = RAM_ACC;
                            cnt_d   = CNT_W'(RAM_WAIT - 1);
                        end
                        REG_UDATA: begin
                            state_d = memwrite_i ? UART_WR : UART_RD;
                            cnt_d   = CNT_W'(UART_WAIT - 1);
                        end
                        default: begin
                            state_d = DONE;
                            if (!memwrite_i) begin
                                rdata_d = DATA_W'({uart_data_ready_i, uart_tbre_i & uart_tsre_i});
                            end
                        end
                    endcase
                end
            end
            RAM_ACC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!write_q) begin
                        rdata_d = (region_q == REG_RAM1) ? ram1_din_i : ram2_din_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            UART_RD: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    rdata_d = DATA_W'(ram1_din_i[7:0]);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            UART_WR: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are computed from the next state so they change only on clock edges
    always_comb begin
        ram_acc_c  = (state_d == RAM_ACC);
        ram1_en_d  = !(ram_acc_c && (region_d == REG_RAM1));
        ram1_oe_d  = !(ram_acc_c && (region_d == REG_RAM1) && !write_d);
        ram1_we_d  = !(ram_acc_c && (region_d == REG_RAM1) && write_d);
        ram1_doe_d = (ram_acc_c && (region_d == REG_RAM1) && write_d) || (state_d == UART_WR);
        ram2_en_d  = !(ram_acc_c && (region_d == REG_RAM2));
        ram2_oe_d  = !(ram_acc_c && (region_d == REG_RAM2) && !write_d);
        ram2_we_d  = !(ram_acc_c && (region_d == REG_RAM2) && write_d);
        ram2_doe_d = ram_acc_c && (region_d == REG_RAM2) && write_d;
        rdn_d      = (state_d != UART_RD);
        wrn_d      = (state_d != UART_WR);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            region_q   <= REG_RAM2;
            write_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            ram1_en_q  <= 1'b1;
            ram1_oe_q  <= 1'b1;
            ram1_we_q  <= 1'b1;
            ram1_doe_q <= 1'b0;
            ram2_en_q  <= 1'b1;
            ram2_oe_q  <= 1'b1;
            ram2_we_q  <= 1'b1;
            ram2_doe_q <= 1'b0;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            ram1_en_q  <= ram1_en_d;
            ram1_oe_q  <= ram1_oe_d;
            ram1_we_q  <= ram1_we_d;
            ram1_doe_q <= ram1_doe_d;
            ram2_en_q  <= ram2_en_d;
            ram2_oe_q  <= ram2_oe_d;
            ram2_we_q  <= ram2_we_d;
            ram2_doe_q <= ram2_doe_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && req_c) || (state_q == RAM_ACC) ||
                         (state_q == UART_RD) || (state_q == UART_WR);
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign ram1_en_o   = ram1_en_q;
    assign ram1_oe_o   = ram1_oe_q;
    assign ram1_we_o   = ram1_we_q;
    assign ram2_en_o   = ram2_en_q;
    assign ram2_oe_o   = ram2_oe_q;
    assign ram2_we_o   = ram2_we_q;
    assign ram_addr_o  = addr_q;
    assign ram1_dout_o = wdata_q;
    assign ram2_dout_o = wdata_q;
    assign ram1_doe_o  = ram1_doe_q;
    assign ram2_doe_o  = ram2_doe_q;
    assign uart_rdn_o  = rdn_q;
    assign uart_wrn_o  = wrn_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: dut_a uses RAM_WAIT=1, dut_b RAM_WAIT=3,
// both driven by the same stimulus.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] addr, wdata, ram1_din, ram2_din;
    logic        memread, memwrite;
    logic        dready, tbre, tsre;

    logic [15:0] a_rdata, a_raddr, a_r1dout, a_r2dout;
    logic        a_done, a_stall, a_r1en, a_r1oe, a_r1we, a_r2en, a_r2oe, a_r2we;
    logic        a_r1doe, a_r2doe, a_rdn, a_wrn;
    logic [15:0] b_rdata, b_raddr, b_r1dout, b_r2dout;
    logic        b_done, b_stall, b_r1en, b_r1oe, b_r1we, b_r2en, b_r2oe, b_r2we;
    logic        b_r1doe, b_r2doe, b_rdn, b_wrn;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.RAM_WAIT(1), .UART_WAIT(2)) dut_a (
        .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata),
        .memread_i(memread), .memwrite_i(memwrite),
        .rdata_o(a_rdata), .done_o(a_done), .stall_o(a_stall),
        .ram1_en_o(a_r1en), .ram1_oe_o(a_r1oe), .ram1_we_o(a_r1we),
        .ram2_en_o(a_r2en), .ram2_oe_o(a_r2oe), .ram2_we_o(a_r2we),
        .ram_addr_o(a_raddr), .ram1_dout_o(a_r1dout), .ram2_dout_o(a_r2dout),
        .ram1_doe_o(a_r1doe), .ram2_doe_o(a_r2doe),
        .ram1_din_i(ram1_din), .ram2_din_i(ram2_din),
        .uart_rdn_o(a_rdn), .uart_wrn_o(a_wrn),
        .uart_data_ready_i(dready), .uart_tbre_i(tbre), .uart_tsre_i(tsre)
    );

    mem_access_ctrl #(.RAM_WAIT(3), .UART_WAIT(2)) dut_b (
        .clk(clk), .rst(rst), .addr_i(addr), .wdata_i(wdata),
        .memread_i(memread), .memwrite_i(memwrite),
        .rdata_o(b_rdata), .done_o(b_done), .stall_o(b_stall),
        .ram1_en_o(b_r1en), .ram1_oe_o(b_r1oe), .ram1_we_o(b_r1we),
        .ram2_en_o(b_r2en), .ram2_oe_o(b_r2oe), .ram2_we_o(b_r2we),
        .ram_addr_o(b_raddr), .ram1_dout_o(b_r1dout), .ram2_dout_o(b_r2dout),
        .ram1_doe_o(b_r1doe), .ram2_doe_o(b_r2doe),
        .ram1_din_i(ram1_din), .ram2_din_i(ram2_din),
        .uart_rdn_o(b_rdn), .uart_wrn_o(b_wrn),
        .uart_data_ready_i(dready), .uart_tbre_i(tbre), .uart_tsre_i(tsre)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a();
        chk("a_rst_r1en", a_r1en, 1);   chk("a_rst_r1oe", a_r1oe, 1);
        chk("a_rst_r1we", a_r1we, 1);   chk("a_rst_r2en", a_r2en, 1);
        chk("a_rst_r2oe", a_r2oe, 1);   chk("a_rst_r2we", a_r2we, 1);
        chk("a_rst_r1doe", a_r1doe, 0); chk("a_rst_r2doe", a_r2doe, 0);
        chk("a_rst_rdn", a_rdn, 1);     chk("a_rst_wrn", a_wrn, 1);
        chk("a_rst_rdata", a_rdata, 0); chk("a_rst_done", a_done, 0);
        chk("a_rst_raddr", a_raddr, 0); chk("a_rst_stall", a_stall, 0);
        chk("a_rst_r1dout", a_r1dout, 0); chk("a_rst_r2dout", a_r2dout, 0);
    endtask

    task automatic chk_reset_b();
        chk("b_rst_r1en", b_r1en, 1);   chk("b_rst_r1oe", b_r1oe, 1);
        chk("b_rst_r1we", b_r1we, 1);   chk("b_rst_r2en", b_r2en, 1);
        chk("b_rst_r2oe", b_r2oe, 1);   chk("b_rst_r2we", b_r2we, 1);
        chk("b_rst_r1doe", b_r1doe, 0); chk("b_rst_r2doe", b_r2doe, 0);
        chk("b_rst_rdn", b_rdn, 1);     chk("b_rst_wrn", b_wrn, 1);
        chk("b_rst_rdata", b_rdata, 0); chk("b_rst_done", b_done, 0);
        chk("b_rst_raddr", b_raddr, 0); chk("b_rst_stall", b_stall, 0);
        chk("b_rst_r1dout", b_r1dout, 0); chk("b_rst_r2dout", b_r2dout, 0);
    endtask

    initial begin
        rst = 1'b0; addr = '0; wdata = '0; memread = 1'b0; memwrite = 1'b0;
        ram1_din = 16'hFF5A; ram2_din = 16'h1234;
        dready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        #12;
        chk_reset_a();
        chk_reset_b();
        tick(); rst = 1'b1;
        tick(); tick();

        // RAM2 read, 0x0010
        addr = 16'h0010; memread = 1'b1;
        #1 chk("t1_c0_stall", a_stall, 1); chk("t1_c0_r2en", a_r2en, 1);
        tick(); memread = 1'b0;
        chk("t1_c1_r2en", a_r2en, 0);   chk("t1_c1_r2oe", a_r2oe, 0);
        chk("t1_c1_r2we", a_r2we, 1);   chk("t1_c1_r2doe", a_r2doe, 0);
        chk("t1_c1_r1en", a_r1en, 1);   chk("t1_c1_raddr", a_raddr, 16'h0010);
        chk("t1_c1_stall", a_stall, 1); chk("t1_c1_done", a_done, 0);
        tick();
        chk("t1_c2_done", a_done, 1);   chk("t1_c2_rdata", a_rdata, 16'h1234);
        chk("t1_c2_stall", a_stall, 0); chk("t1_c2_r2en", a_r2en, 1);
        chk("t1_c2_r1en", a_r1en, 1);
        tick();
        chk("t1_c3_done", a_done, 0);   chk("t1_c3_rdata", a_rdata, 16'h1234);
        chk("t1_c3_b_done", b_done, 0);
        tick();
        chk("t1_c4_b_done", b_done, 1); chk("t1_c4_b_rdata", b_rdata, 16'h1234);
        tick(); tick();

        // RAM1 write on the RAM_WAIT=3 instance
        addr = 16'h8000; wdata = 16'hABCD; memwrite = 1'b1;
        tick(); memwrite = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("t2_b_r1we", b_r1we, 0);     chk("t2_b_r1doe", b_r1doe, 1);
            chk("t2_b_r1dout", b_r1dout, 16'hABCD);
            chk("t2_b_r1en", b_r1en, 0);     chk("t2_b_r1oe", b_r1oe, 1);
            chk("t2_b_r2en", b_r2en, 1);     chk("t2_b_done", b_done, 0);
            chk("t2_b_stall", b_stall, 1);
            tick();
        end
        chk("t2_c4_b_done", b_done, 1);   chk("t2_c4_b_rdata", b_rdata, 16'h1234);
        chk("t2_c4_b_r1we", b_r1we, 1);   chk("t2_c4_b_r1doe", b_r1doe, 0);
        chk("t2_a_rdata", a_rdata, 16'h1234);
        tick(); tick();

        // UART data write then read at 0xBF00
        addr = 16'hBF00; wdata = 16'h0041; memwrite = 1'b1;
        tick(); memwrite = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            chk("t3w_wrn", a_wrn, 0);      chk("t3w_r1en", a_r1en, 1);
            chk("t3w_r1oe", a_r1oe, 1);    chk("t3w_r1doe", a_r1doe, 1);
            chk("t3w_r1dout", a_r1dout, 16'h0041);
            chk("t3w_rdn", a_rdn, 1);      chk("t3w_done", a_done, 0);
            tick();
        end
        chk("t3w_c3_done", a_done, 1);  chk("t3w_c3_wrn", a_wrn, 1);
        chk("t3w_c3_r1doe", a_r1doe, 0); chk("t3w_c3_rdata", a_rdata, 16'h1234);
        tick(); tick();
        memread = 1'b1;
        tick(); memread = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            chk("t3r_rdn", a_rdn, 0);      chk("t3r_r1en", a_r1en, 1);
            chk("t3r_r1oe", a_r1oe, 1);    chk("t3r_r1doe", a_r1doe, 0);
            chk("t3r_done", a_done, 0);
            tick();
        end
        chk("t3r_c3_done", a_done, 1);  chk("t3r_c3_rdata", a_rdata, 16'h005A);
        chk("t3r_c3_rdn", a_rdn, 1);
        tick(); tick();

        // Status read/write at 0xBF01
        addr = 16'hBF01; dready = 1'b1; tbre = 1'b1; tsre = 1'b0; memread = 1'b1;
        #1 chk("t4_c0_stall", a_stall, 1);
        tick(); memread = 1'b0;
        chk("t4_c1_done", a_done, 1);   chk("t4_c1_rdata", a_rdata, 16'h0002);
        chk("t4_c1_rdn", a_rdn, 1);     chk("t4_c1_wrn", a_wrn, 1);
        chk("t4_c1_r1en", a_r1en, 1);   chk("t4_c1_r2en", a_r2en, 1);
        chk("t4_c1_stall", a_stall, 0);
        tick();
        tsre = 1'b1; memwrite = 1'b1;
        tick(); memwrite = 1'b0;
        chk("t4w_done", a_done, 1);     chk("t4w_rdata", a_rdata, 16'h0002);
        tick(); tick();

        // Region boundaries
        addr = 16'h7FFF; memread = 1'b1;
        tick(); memread = 1'b0;
        chk("b7fff_r2en", a_r2en, 0);   chk("b7fff_r1en", a_r1en, 1);
        tick();
        chk("b7fff_rdata", a_rdata, 16'h1234);
        tick(); tick(); tick();
        addr = 16'hBF02; memread = 1'b1;
        tick(); memread = 1'b0;
        chk("bbf02_r1en", a_r1en, 0);   chk("bbf02_r1oe", a_r1oe, 0);
        chk("bbf02_rdn", a_rdn, 1);     chk("bbf02_r2en", a_r2en, 1);
        tick();
        chk("bbf02_done", a_done, 1);   chk("bbf02_rdata", a_rdata, 16'hFF5A);
        tick(); tick(); tick();

        // Request held across DONE: no restart in DONE, restart in next IDLE
        addr = 16'h0010; memread = 1'b1;
        tick(); chk("t5_c1_r2en", a_r2en, 0);
        tick(); chk("t5_c2_done", a_done, 1); chk("t5_c2_stall", a_stall, 0);
        tick(); chk("t5_c3_stall", a_stall, 1); chk("t5_c3_r2en", a_r2en, 1);
        chk("t5_c3_done", a_done, 0);
        tick(); memread = 1'b0; chk("t5_c4_r2en", a_r2en, 0);
        tick(); chk("t5_c5_done", a_done, 1);
        tick(); tick(); tick();

        // Read and write together -> write
        addr = 16'h0020; wdata = 16'h5555; memread = 1'b1; memwrite = 1'b1;
        tick(); memread = 1'b0; memwrite = 1'b0;
        chk("t5rw_r2we", a_r2we, 0);    chk("t5rw_r2oe", a_r2oe, 1);
        chk("t5rw_r2doe", a_r2doe, 1);  chk("t5rw_r2dout", a_r2dout, 16'h5555);
        tick();
        chk("t5rw_done", a_done, 1);    chk("t5rw_rdata", a_rdata, 16'h1234);
        tick(); tick(); tick();

        // Reset in the middle of a RAM2 write
        addr = 16'h0030; wdata = 16'h7777; memwrite = 1'b1;
        tick(); memwrite = 1'b0;
        chk("t6_pre_r2we", a_r2we, 0);  chk("t6_pre_r2doe", a_r2doe, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_r2we", a_r2we, 1);  chk("t6_rst_r2doe", a_r2doe, 0);
        chk("t6_rst_r2en", a_r2en, 1);  chk("t6_rst_raddr", a_raddr, 0);
        chk("t6_rst_stall", a_stall, 0);
        tick(); chk("t6_rst_done", a_done, 0);
        tick(); rst = 1'b1;
        tick();
        chk("t6_post_done", a_done, 0); chk("t6_post_stall", a_stall, 0);
        chk("t6_post_r2en", a_r2en, 1);
        addr = 16'hBF01; memread = 1'b1;
        tick(); memread = 1'b0;
        chk("t6_idle_stat_done", a_done, 1);
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequential memory/peripheral access controller for the MEM stage. It decodes the MEM-stage address into RAM2, RAM1, UART-data or UART-status regions, with configurable region boundaries. It then runs a multi-cycle, wait-stated access FSM that drives the external SRAM and UART strobes. It stalls the pipeline until the access completes and returns registered read data.

Parameters:
DATA_W, 16, CPU data / SRAM data width
ADDR_W, 16, CPU address width
RAM1_BASE, 16'h8000, addresses >= this go to RAM1 (below: RAM2)
UART_DATA_ADDR, 16'hBF00, UART data register address (inside RAM1 range, overrides RAM1)
UART_STAT_ADDR, 16'hBF01, UART status register address (overrides RAM1)
RAM_WAIT, 1, cycles the SRAM strobe is held low (>=1)
UART_WAIT, 2, cycles rdn/wrn is held low (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
addr_i  in  ADDR_W  access address (ALU result)
wdata_i  in  DATA_W  store data
memread_i  in  1  load request
memwrite_i  in  1  store request
rdata_o  out  DATA_W  registered load result, valid when done_o=1
done_o  out  1  one-cycle pulse: access complete
stall_o  out  1  hold pipeline while access in progress
ram1_en_o / ram1_oe_o / ram1_we_o  out  1 each  RAM1 chip enable / output enable / write enable, active-low
ram2_en_o / ram2_oe_o / ram2_we_o  out  1 each  RAM2 equivalents, active-low
ram_addr_o  out  ADDR_W  SRAM address (RAM1 and RAM2 share the address bus)
ram1_dout_o / ram2_dout_o  out  DATA_W  write data per bus
ram1_doe_o / ram2_doe_o  out  1  tristate drive enable per data bus, active-high
ram1_din_i / ram2_din_i  in  DATA_W  data bus read-back
uart_rdn_o / uart_wrn_o  out  1  UART read/write strobes, active-low (UART shares RAM1 data bus)
uart_data_ready_i, uart_tbre_i, uart_tsre_i  in  1 each  UART status flags

Behaviour:
- Reset (async, rst=0): state IDLE; all active-low strobes/enables = 1; doe outputs = 0; rdata_o = 0; done_o = 0; ram_addr_o = 0. Effective immediately, including mid-access; in-flight access is abandoned with no done_o pulse.
- States: IDLE, RAM_ACC, UART_RD, UART_WR, DONE.
- Decode, evaluated in IDLE only:
  - addr == UART_STAT_ADDR -> STAT
  - addr == UART_DATA_ADDR -> UDATA
  - addr >= RAM1_BASE -> RAM1
  - else -> RAM2
  - Compares are unsigned.
- Request detection: IDLE && (memread_i || memwrite_i). If both are asserted, treat as a write. On request, latch addr, wdata, region and direction; stall_o=1 combinationally in this same cycle.
- stall_o = (IDLE && request) || state in {RAM_ACC, UART_RD, UART_WR}. stall_o=0 in DONE.
- RAM1/RAM2 access: IDLE -> RAM_ACC for RAM_WAIT cycles, counted by a down-counter.
  - Selected en_o=0 for the whole of RAM_ACC; the other RAM's en_o=1.
  - Read: oe_o=0, doe=0. Write: we_o=0, doe=1, dout=latched wdata.
  - ram_addr_o = latched addr, held stable throughout.
  - On the last RAM_ACC cycle (read): capture din into rdata_o. Then -> DONE.
- UDATA access: ram1_en_o=1 and ram1_oe_o=1 throughout, to free the shared bus.
  - Read: UART_RD, uart_rdn_o=0 for UART_WAIT cycles; on the last cycle rdata_o = zero-extended ram1_din_i[7:0].
  - Write: UART_WR, uart_wrn_o=0 for UART_WAIT cycles, ram1_doe_o=1, ram1_dout_o=wdata.
  - Then -> DONE.
- STAT access, no external strobe: IDLE -> DONE directly.
  - Read: rdata_o = {0..., uart_data_ready_i, uart_tbre_i & uart_tsre_i}, sampled at the request cycle edge.
  - Write: ignored, completes normally.
- DONE: done_o=1 for one cycle; all strobes inactive; -> IDLE unconditionally. Request inputs seen in DONE are not started (the pipeline advances on this edge).
- Latencies (request cycle = cycle 0):
  - RAM: done at cycle RAM_WAIT+1.
  - UART data: done at cycle UART_WAIT+1.
  - STAT: done at cycle 1.
- rdata_o holds its value until the next read completes; writes leave it unchanged.
- Strobes are registered outputs, glitch-free. Addr/data become stable one cycle before, or coincident with, the strobe falling edge.

Test Plan:
- Reset mid-access: assert rst=0 during RAM_ACC of a RAM2 write -> ram2_we_o=1 and ram2_doe_o=0 immediately, no done_o pulse, state IDLE after release.
- RAM2 read addr=16'h0010, din=16'h1234, RAM_WAIT=1 -> ram2_en_o/oe_o low for 1 cycle, stall_o high cycles 0-1, done_o at cycle 2, rdata_o=16'h1234, ram1_en_o=1 throughout.
- RAM1 write addr=16'h8000, wdata=16'hABCD, RAM_WAIT=3 -> ram1_we_o low 3 cycles, ram1_doe_o=1 with dout=ABCD, done_o at cycle 4, rdata_o unchanged.
- UART write addr=16'hBF00, wdata=16'h0041 -> uart_wrn_o low 2 cycles, ram1_en_o=1, ram1_dout_o=0041, done_o at cycle 3; the same address as a read with din=16'hFF5A -> rdata_o=16'h005A.
- Status read addr=16'hBF01, data_ready=1, tbre=1, tsre=0 -> rdata_o=16'h0002, done_o at cycle 1, no strobe toggles; boundary: addr=16'h7FFF goes to RAM2, 16'hBF02 goes to RAM1.
- Back-to-back: memread_i held high across DONE -> no restart in DONE, new access starts in the following IDLE cycle; memread_i=memwrite_i=1 -> a write is performed.
